// File: rtl/vga_scan_controller.sv
// VGA raster timing generator and pixel streamer, 640x480@60 by default.
// Ports: vga_clock/reset_n in; fb_x/fb_y read address out, fb_pixel in;
//   r,g,b, hsync, vsync, in_display, count_x, count_y, frame_start out.
module vga_scan_controller #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       vga_clock,
   input  logic       reset_n,
   output logic [9:0] fb_x,
   output logic [9:0] fb_y,
   input  logic [2:0] fb_pixel,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic       hsync,
   output logic       vsync,
   output logic       in_display,
   output logic [9:0] count_x,
   output logic [9:0] count_y,
   output logic       frame_start
);

   localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
   localparam logic [9:0] H_SS  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SE  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST =
      10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);

   localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
   localparam logic [9:0] V_SS  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SE  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST =
      10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_last;
   logic       v_last;
   logic       vis;
   logic       hs_on;
   logic       vs_on;
   logic       origin;

   assign fb_x = h_cnt;
   assign fb_y = v_cnt;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Decode from the pre-edge counters so every output moves together.
   assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign hs_on  = (h_cnt >= H_SS) && (h_cnt < H_SE);
   assign vs_on  = (v_cnt >= V_SS) && (v_cnt < V_SE);
   assign origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         r           <= 1'b0;
         g           <= 1'b0;
         b           <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         in_display  <= 1'b0;
         count_x     <= '0;
         count_y     <= '0;
         frame_start <= 1'b0;
      end else begin
         {r, g, b}   <= vis ? fb_pixel : 3'b000;
         hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
         in_display  <= vis;
         count_x     <= h_cnt;
         count_y     <= v_cnt;
         frame_start <= origin;
      end
   end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller: full-size line timing plus a
// shrunken-timing instance for whole-frame, wrap and vsync behaviour.
module tb_vga_scan_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode = 1'b0;

   logic [9:0] fbx_m, fby_m, cx_m, cy_m;
   logic [2:0] pix_m;
   logic       r_m, g_m, b_m, hs_m, vs_m, de_m, fs_m;

   logic [9:0] fbx_s, fby_s, cx_s, cy_s;
   logic [2:0] pix_s;
   logic       r_s, g_s, b_s, hs_s, vs_s, de_s, fs_s;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   assign pix_m = mode ? (fbx_m[2:0] ^ fby_m[2:0]) : 3'b101;
   assign pix_s = mode ? (fbx_s[2:0] ^ fby_s[2:0]) : 3'b101;

   vga_scan_controller u_main (
      .vga_clock(clk), .reset_n(rst_n),
      .fb_x(fbx_m), .fb_y(fby_m), .fb_pixel(pix_m),
      .r(r_m), .g(g_m), .b(b_m),
      .hsync(hs_m), .vsync(vs_m), .in_display(de_m),
      .count_x(cx_m), .count_y(cy_m), .frame_start(fs_m)
   );

   vga_scan_controller #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_small (
      .vga_clock(clk), .reset_n(rst_n),
      .fb_x(fbx_s), .fb_y(fby_s), .fb_pixel(pix_s),
      .r(r_s), .g(g_s), .b(b_s),
      .hsync(hs_s), .vsync(vs_s), .in_display(de_s),
      .count_x(cx_s), .count_y(cy_s), .frame_start(fs_s)
   );

   localparam logic [26:0] RST_OUT = {20'd0, 3'b000, 4'b1100};

   int ex, ey, sx, sy, lx;
   int cyc, hs_low_m, vis_m, vis_s, vs_low_s, fs_cnt_s, fs_prev_s;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] model(
      input int x, input int y, input int hv, input int hf, input int hw,
      input int vv, input int vf, input int vw, input logic md);
      logic vis, hs, vs, fs;
      logic [2:0] p;
      vis = (x < hv) && (y < vv);
      hs  = !((x >= hv + hf) && (x <= hv + hf + hw - 1));
      vs  = !((y >= vv + vf) && (y <= vv + vf + vw - 1));
      fs  = (x == 0) && (y == 0);
      p   = md ? 3'(x ^ y) : 3'b101;
      return {10'(x), 10'(y), vis ? p : 3'b000, hs, vs, vis, fs};
   endfunction

   function automatic logic [26:0] got_m();
      return {cx_m, cy_m, r_m, g_m, b_m, hs_m, vs_m, de_m, fs_m};
   endfunction

   function automatic logic [26:0] got_s();
      return {cx_s, cy_s, r_s, g_s, b_s, hs_s, vs_s, de_s, fs_s};
   endfunction

   task automatic restart_models();
      ex = 0; ey = 0; sx = 0; sy = 0;
      fs_prev_s = -1;
   endtask

   task automatic clear_stats();
      hs_low_m = 0; vis_m = 0; vis_s = 0; vs_low_s = 0; fs_cnt_s = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         check("scan_main", 32'(got_m()),
               32'(model(ex, ey, 640, 16, 96, 480, 10, 2, mode)));
         check("scan_small", 32'(got_s()),
               32'(model(sx, sy, 8, 2, 3, 6, 2, 2, mode)));
         if (!hs_m) hs_low_m++;
         if (de_m) vis_m++;
         if (de_s) vis_s++;
         if (!vs_s) vs_low_s++;
         if (fs_s) begin
            fs_cnt_s++;
            if (fs_prev_s >= 0)
               check("fs_period", 32'(cyc - fs_prev_s), 32'd192);
            fs_prev_s = cyc;
         end
         lx = ex;
         if (ex == 799) begin
            ex = 0;
            ey = (ey == 524) ? 0 : ey + 1;
         end else ex++;
         if (sx == 15) begin
            sx = 0;
            sy = (sy == 11) ? 0 : sy + 1;
         end else sx++;
      end
   endtask

   initial begin
      int guard;
      cyc = 0;
      restart_models();
      clear_stats();

      repeat (3) @(negedge clk);
      check("rst_main", 32'(got_m()), 32'(RST_OUT));
      check("rst_small", 32'(got_s()), 32'(RST_OUT));
      check("rst_fb", {12'd0, fbx_m, fby_m}, 32'd0);

      rst_n = 1'b1;
      restart_models();
      run(4800);
      check("hs_low_6lines", hs_low_m, 32'd576);
      check("vis_6lines", vis_m, 32'd3840);
      check("vis_25frames", vis_s, 32'd1200);
      check("vs_low_25frames", vs_low_s, 32'd800);
      check("fs_25frames", fs_cnt_s, 32'd25);

      mode = 1'b1;
      clear_stats();
      run(1600);
      check("vis_fn_2lines", vis_m, 32'd1280);

      guard = 0;
      lx = -1;
      while (lx != 300 && guard < 2000) begin
         run(1);
         guard++;
      end
      check("reach_300", 32'(lx), 32'd300);
      check("mid_row", {22'd0, cy_m}, 32'd8);

      #3 rst_n = 1'b0;
      #1;
      check("async_main", 32'(got_m()), 32'(RST_OUT));
      check("async_small", 32'(got_s()), 32'(RST_OUT));
      check("async_fb", {12'd0, fbx_m, fby_m}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("hold_main", 32'(got_m()), 32'(RST_OUT));
         check("hold_fb", {12'd0, fbx_m, fby_m}, 32'd0);
      end

      rst_n = 1'b1;
      restart_models();
      mode = 1'b0;
      clear_stats();
      run(900);
      check("fs_after_restart", fs_cnt_s, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
